// File: rtl/rom_load_pkg.sv
// ---------------------------------------------------------------------------
// rom_load_pkg
// Shared types and constants for the cartridge download controller.
//   rom_load_state_t : controller state encoding
//   ROM_MASK_MAX     : widest possible cart address mask (24 bits)
//   RAM_SIZE_CLAMP   : largest SRAM size code honoured (128 KiB)
//   MASK_SAT_CODE    : first size code whose mask fills all 24 bits
// ---------------------------------------------------------------------------
package rom_load_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WR_LO,
    WR_HI,
    SETTLE,
    CFG
  } rom_load_state_t;

  localparam logic [23:0] ROM_MASK_MAX   = 24'hFFFFFF;
  localparam logic [7:0]  RAM_SIZE_CLAMP = 8'd7;
  localparam logic [7:0]  MASK_SAT_CODE  = 8'd14;

endpackage

// File: rtl/rom_size_to_mask.sv
// ---------------------------------------------------------------------------
// rom_size_to_mask
// Converts a header size code into a cart address mask:
//   mask = (1 KiB << code) - 1, saturating to 24 bits.
// Ports:
//   size_i      in  8   size code from the header parser
//   zero_none_i in  1   when set, code 0 means "no memory" and yields mask 0
//   mask_o      out 24  resulting address mask
// Purely combinational.
// ---------------------------------------------------------------------------
module rom_size_to_mask
  import rom_load_pkg::*;
(
  input  logic [7:0]  size_i,
  input  logic        zero_none_i,
  output logic [23:0] mask_o
);

  always_comb begin
    if (zero_none_i && (size_i == 8'd0)) begin
      mask_o = 24'd0;
    end else if (size_i >= MASK_SAT_CODE) begin
      // Code 14 already fills 24 bits; larger codes would overflow the shift.
      mask_o = ROM_MASK_MAX;
    end else begin
      mask_o = 24'((32'h400 << size_i) - 32'd1);
    end
  end

endmodule

// File: rtl/rom_load_ctrl.sv
// ---------------------------------------------------------------------------
// rom_load_ctrl
// Cartridge download sequencer. Takes 32-bit words from the bridge, writes
// them as two 16-bit halves to cart memory over a req/ack handshake, mirrors
// every half onto the header-parser tap, then publishes a one-shot mapper
// configuration once the parser has had time to settle.
//
// Optional feature: define ROM_LOAD_HEADER_SKIP_EN to drop the copier header
// (first HEADER_BYTES of a file flagged by has_header) from memory and shift
// all later writes down by HEADER_BYTES.
//
// Ports:
//   clk_mem, reset                 clock, asynchronous active-high reset
//   dl_start, rom_file_size        load start pulse and file length (bytes)
//   in_valid/in_ready/in_data      bridge word stream, byte0 = in_data[7:0]
//   mem_req/mem_ack                memory write handshake
//   mem_addr, mem_data             write address (bit0 = 0) and half-word
//   parse_addr, parse_data         raw file offset and half-word for parser
//   downloading                    high while bytes remain to be written
//   has_header, parsed_*           parser verdict
//   cfg_valid, cfg_*               one-shot mapper configuration
// ---------------------------------------------------------------------------
module rom_load_ctrl
  import rom_load_pkg::*;
#(
  parameter int HEADER_BYTES  = 512,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk_mem,
  input  logic        reset,
  input  logic        dl_start,
  input  logic [31:0] rom_file_size,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_data,
  output logic [24:0] parse_addr,
  output logic [15:0] parse_data,
  output logic        downloading,
  input  logic        has_header,
  input  logic [7:0]  parsed_rom_type,
  input  logic [7:0]  parsed_rom_size,
  input  logic [7:0]  parsed_sram_size,
  output logic        cfg_valid,
  output logic [7:0]  cfg_rom_type,
  output logic [23:0] cfg_rom_mask,
  output logic [23:0] cfg_ram_mask
);

  localparam logic [31:0]     HDR_LEN     = 32'(HEADER_BYTES);
  localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam rom_load_state_t DONE_STATE  = (SETTLE_CYCLES > 0) ? SETTLE : CFG;

  rom_load_state_t state_q;
  logic [7:0]  settle_q;
  logic [31:0] total_q;
  logic [31:0] cnt_q;
  logic [15:0] hi_q;
  logic        skip_q;
  logic        in_ready_q;
  logic        mem_req_q;
  logic [23:0] mem_addr_q;
  logic [15:0] mem_data_q;
  logic [24:0] parse_addr_q;
  logic [15:0] parse_data_q;
  logic        downloading_q;
  logic        cfg_valid_q;
  logic [7:0]  cfg_rom_type_q;
  logic [23:0] cfg_rom_mask_q;
  logic [23:0] cfg_ram_mask_q;

  logic [31:0] total_d;
  logic [31:0] cnt_d;
  logic [31:0] half_cnt;
  logic [15:0] half_data;
  logic [23:0] half_addr;
  logic        hdr_active;
  logic        half_skip;
  logic        half_done;
  logic        last_half;
  logic        start_half;
  logic [7:0]  ram_code;
  logic [23:0] rom_mask;
  logic [23:0] ram_mask;

  always_comb begin
    total_d = rom_file_size + {31'd0, rom_file_size[0]};
    cnt_d   = cnt_q + 32'd2;
`ifdef ROM_LOAD_HEADER_SKIP_EN
    hdr_active = has_header;
`else
    // Without header skipping the flag never affects addressing.
    hdr_active = 1'b0 & has_header;
`endif
    // The half being entered: the low half of a freshly accepted word, or
    // the high half of the word currently in flight.
    half_cnt   = (state_q == FETCH) ? cnt_q : cnt_d;
    half_data  = (state_q == FETCH) ? in_data[15:0] : hi_q;
    half_skip  = hdr_active && (half_cnt < HDR_LEN);
    half_addr  = 24'(half_cnt - (hdr_active ? HDR_LEN : 32'd0));
    half_done  = skip_q || (mem_req_q && mem_ack);
    last_half  = (cnt_d == total_q);
    start_half = ((state_q == FETCH) && in_valid) ||
                 ((state_q == WR_LO) && half_done && !last_half);
    ram_code   = (parsed_sram_size > RAM_SIZE_CLAMP) ? RAM_SIZE_CLAMP : parsed_sram_size;
  end

  rom_size_to_mask u_rom_mask (
    .size_i      (parsed_rom_size),
    .zero_none_i (1'b0),
    .mask_o      (rom_mask)
  );

  rom_size_to_mask u_ram_mask (
    .size_i      (ram_code),
    .zero_none_i (1'b1),
    .mask_o      (ram_mask)
  );

  always_ff @(posedge clk_mem or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      settle_q       <= '0;
      total_q        <= '0;
      cnt_q          <= '0;
      hi_q           <= '0;
      skip_q         <= 1'b0;
      in_ready_q     <= 1'b0;
      mem_req_q      <= 1'b0;
      mem_addr_q     <= '0;
      mem_data_q     <= '0;
      parse_addr_q   <= '0;
      parse_data_q   <= '0;
      downloading_q  <= 1'b0;
      cfg_valid_q    <= 1'b0;
      cfg_rom_type_q <= '0;
      cfg_rom_mask_q <= '0;
      cfg_ram_mask_q <= '0;
    end else begin
      cfg_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dl_start) begin
            total_q  <= total_d;
            cnt_q    <= '0;
            settle_q <= '0;
            if (total_d == 32'd0) begin
              // Empty file: nothing to write, go straight to the verdict wait.
              state_q       <= DONE_STATE;
              downloading_q <= 1'b0;
            end else begin
              state_q       <= FETCH;
              in_ready_q    <= 1'b1;
              downloading_q <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (in_valid) begin
            hi_q       <= in_data[31:16];
            in_ready_q <= 1'b0;
            state_q    <= WR_LO;
          end
        end
        WR_LO, WR_HI: begin
          if (half_done) begin
            cnt_q     <= cnt_d;
            mem_req_q <= 1'b0;
            if (last_half) begin
              // Also drops the unused high half of a short final word.
              state_q       <= DONE_STATE;
              downloading_q <= 1'b0;
              settle_q      <= '0;
            end else if (state_q == WR_LO) begin
              state_q <= WR_HI;
            end else begin
              state_q    <= FETCH;
              in_ready_q <= 1'b1;
            end
          end
        end
        SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            state_q <= CFG;
          end else begin
            settle_q <= settle_q + 8'd1;
          end
        end
        CFG: begin
          cfg_rom_type_q <= parsed_rom_type;
          cfg_rom_mask_q <= rom_mask;
          cfg_ram_mask_q <= ram_mask;
          cfg_valid_q    <= 1'b1;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // Load the outputs for the half being entered; placed after the case
      // so the new request overrides the mem_req drop of the previous half.
      if (start_half) begin
        skip_q       <= half_skip;
        mem_req_q    <= !half_skip;
        mem_addr_q   <= half_addr;
        mem_data_q   <= half_data;
        parse_addr_q <= half_cnt[24:0];
        parse_data_q <= half_data;
      end
    end
  end

  assign in_ready     = in_ready_q;
  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data     = mem_data_q;
  assign parse_addr   = parse_addr_q;
  assign parse_data   = parse_data_q;
  assign downloading  = downloading_q;
  assign cfg_valid    = cfg_valid_q;
  assign cfg_rom_type = cfg_rom_type_q;
  assign cfg_rom_mask = cfg_rom_mask_q;
  assign cfg_ram_mask = cfg_ram_mask_q;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rom_load_ctrl
// Bench for rom_load_ctrl: table of load/configuration vectors plus
// hand-written sequences for the headered file, random ack stalls and a
// reset during a stalled write. Expected writes and parser-tap halves are
// queued when words are driven and popped as the DUT completes each half.
// ---------------------------------------------------------------------------
module tb_rom_load_ctrl;

`ifdef ROM_LOAD_HEADER_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic        clk_mem = 1'b0;
  logic        reset = 1'b1;
  logic        dl_start = 1'b0;
  logic [31:0] rom_file_size = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [23:0] mem_addr;
  logic [15:0] mem_data;
  logic [24:0] parse_addr;
  logic [15:0] parse_data;
  logic        downloading;
  logic        has_header = 1'b0;
  logic [7:0]  parsed_rom_type = '0;
  logic [7:0]  parsed_rom_size = '0;
  logic [7:0]  parsed_sram_size = '0;
  logic        cfg_valid;
  logic [7:0]  cfg_rom_type;
  logic [23:0] cfg_rom_mask;
  logic [23:0] cfg_ram_mask;

  rom_load_ctrl dut (
    .clk_mem          (clk_mem),
    .reset            (reset),
    .dl_start         (dl_start),
    .rom_file_size    (rom_file_size),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .mem_req          (mem_req),
    .mem_ack          (mem_ack),
    .mem_addr         (mem_addr),
    .mem_data         (mem_data),
    .parse_addr       (parse_addr),
    .parse_data       (parse_data),
    .downloading      (downloading),
    .has_header       (has_header),
    .parsed_rom_type  (parsed_rom_type),
    .parsed_rom_size  (parsed_rom_size),
    .parsed_sram_size (parsed_sram_size),
    .cfg_valid        (cfg_valid),
    .cfg_rom_type     (cfg_rom_type),
    .cfg_rom_mask     (cfg_rom_mask),
    .cfg_ram_mask     (cfg_ram_mask)
  );

  always #5 clk_mem = ~clk_mem;

  int n_checks = 0;
  int n_pass = 0;
  logic [63:0] exp_wr[$];
  logic [63:0] exp_parse[$];
  int wr_seen = 0;
  int cfg_pulses = 0;
  int ack_mode = 0;    // 0 zero-wait, 1 limited budget then stall, 2 random
  int ack_budget = 0;

  typedef struct {
    logic [31:0] size;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  rtype;
    logic [7:0]  rsize;
    logic [7:0]  ssize;
    logic [23:0] rmask;
    logic [23:0] smask;
    int          nwr;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Drives mem_ack and scores every completed half at the negedge before
  // the completing posedge.
  initial begin
    forever begin
      @(negedge clk_mem);
      if (reset) begin
        mem_ack = 1'b0;
      end else begin
        case (ack_mode)
          0:       mem_ack = mem_req;
          1:       mem_ack = mem_req && (ack_budget > 0);
          default: mem_ack = mem_req && ($urandom_range(0, 1) == 1);
        endcase
        if (ack_mode == 1 && mem_ack) ack_budget--;
        if (cfg_valid) cfg_pulses++;
        if (downloading && !in_ready && (!mem_req || mem_ack)) begin
          if (exp_parse.size() == 0) check("parse_extra", 64'(exp_parse.size()), 64'd1);
          else check("parse_tap", {23'd0, parse_addr, parse_data}, exp_parse.pop_front());
        end
        if (mem_req && mem_ack) begin
          wr_seen++;
          if (exp_wr.size() == 0) check("write_extra", 64'(exp_wr.size()), 64'd1);
          else check("mem_write", {24'd0, mem_addr, mem_data}, exp_wr.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {60'd0, in_ready, mem_req, downloading, cfg_valid}, 64'd0);
    check({tag, "_mem"}, {24'd0, mem_addr, mem_data}, 64'd0);
    check({tag, "_parse"}, {23'd0, parse_addr, parse_data}, 64'd0);
    check({tag, "_cfg"}, {8'd0, cfg_rom_type, cfg_rom_mask, cfg_ram_mask}, 64'd0);
  endtask

  task automatic push_half(input logic [31:0] addr, input logic [15:0] data);
    exp_parse.push_back({23'd0, addr[24:0], data});
    if (!(SKIP_EN && has_header && addr < 32'd512)) begin
      logic [31:0] wa;
      wa = addr - ((SKIP_EN && has_header) ? 32'd512 : 32'd0);
      exp_wr.push_back({24'd0, wa[23:0], data});
    end
  endtask

  // Called at a negedge; returns at the negedge after dl_start was taken.
  task automatic start_load(input logic [31:0] size);
    wr_seen = 0;
    rom_file_size = size;
    dl_start = 1'b1;
    @(negedge clk_mem);
    dl_start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] word, input logic [31:0] base, input logic [31:0] total);
    int n;
    if (base < total) push_half(base, word[15:0]);
    if (base + 32'd2 < total) push_half(base + 32'd2, word[31:16]);
    in_valid = 1'b1;
    in_data = word;
    n = 0;
    while (!in_ready && n < 3000) begin
      @(negedge clk_mem);
      n++;
    end
    if (n >= 3000) check("accept_timeout", 64'(n), 64'd0);
    @(posedge clk_mem);
    @(negedge clk_mem);
    in_valid = 1'b0;
  endtask

  task automatic finish_load(input string tag, input int exp_nwr, input logic [7:0] rtype,
                             input logic [23:0] rmask, input logic [23:0] smask);
    int n;
    int k;
    n = 0;
    while (downloading && n < 3000) begin
      @(negedge clk_mem);
      n++;
    end
    if (n >= 3000) check({tag, "_dl_timeout"}, 64'(n), 64'd0);
    k = 0;
    while (!cfg_valid && k < 20) begin
      @(negedge clk_mem);
      k++;
    end
    check({tag, "_dl_to_cfg"}, 64'(k), 64'd3);
    check({tag, "_rom_type"}, 64'(cfg_rom_type), 64'(rtype));
    check({tag, "_rom_mask"}, 64'(cfg_rom_mask), 64'(rmask));
    check({tag, "_ram_mask"}, 64'(cfg_ram_mask), 64'(smask));
    @(negedge clk_mem);
    check({tag, "_one_shot"}, {63'd0, cfg_valid}, 64'd0);
    check({tag, "_cfg_hold"}, 64'(cfg_rom_mask), 64'(rmask));
    check({tag, "_queues_empty"}, 64'(exp_wr.size() + exp_parse.size()), 64'd0);
    check({tag, "_write_count"}, 64'(wr_seen), 64'(exp_nwr));
    $display("load %s: %0d writes, rom_mask=0x%0h ram_mask=0x%0h", tag, wr_seen, cfg_rom_mask, cfg_ram_mask);
  endtask

  task automatic load_vec(input vec_t v, input string tag);
    logic [31:0] total;
    int nwords;
    has_header = 1'b0;
    parsed_rom_type = v.rtype;
    parsed_rom_size = v.rsize;
    parsed_sram_size = v.ssize;
    total = (v.size + 32'd1) & ~32'd1;
    nwords = int'((total + 32'd3) / 32'd4);
    start_load(v.size);
    for (int w = 0; w < nwords; w++) send_word((w == 0) ? v.w0 : v.w1, 32'(4 * w), total);
    finish_load(tag, v.nwr, v.rtype, v.rmask, v.smask);
  endtask

  initial begin
    int pulses_before;
    logic [31:0] hw;

    //         size   w0            w1            type   rsize  ssize  rmask        smask      nwr
    vecs[0] = '{32'd8, 32'h44332211, 32'h88776655, 8'h21, 8'h0C, 8'd3,  24'h3FFFFF, 24'h001FFF, 4};
    vecs[1] = '{32'd6, 32'hA1B2C3D4, 32'h5566E7F8, 8'h20, 8'd0,  8'd0,  24'h0003FF, 24'h000000, 3};
    vecs[2] = '{32'd5, 32'h0BADF00D, 32'hCAFE1234, 8'h35, 8'd13, 8'd7,  24'h7FFFFF, 24'h01FFFF, 3};
    vecs[3] = '{32'd3, 32'h13579BDF, 32'h0,        8'h23, 8'd14, 8'd8,  24'hFFFFFF, 24'h01FFFF, 2};
    vecs[4] = '{32'd2, 32'hFFFF7777, 32'h0,        8'h30, 8'hFF, 8'd1,  24'hFFFFFF, 24'h0007FF, 1};
    vecs[5] = '{32'd0, 32'h0,        32'h0,        8'h31, 8'd10, 8'hFF, 24'h0FFFFF, 24'h01FFFF, 0};

    repeat (2) @(negedge clk_mem);
    check_all_zero("in_reset");
    reset = 1'b0;
    @(negedge clk_mem);
    check_all_zero("after_reset");

    for (int i = 0; i < 6; i++) load_vec(vecs[i], $sformatf("vec%0d", i));

    // Headered file: 0x208 bytes, 130 words.
    has_header = 1'b1;
    parsed_rom_type = 8'h21;
    parsed_rom_size = 8'h0C;
    parsed_sram_size = 8'd3;
    start_load(32'h208);
    for (int i = 0; i < 130; i++) begin
      hw = {16'h8000 | 16'(2 * i + 1), 16'(2 * i)};
      send_word(hw, 32'(4 * i), 32'h208);
    end
    finish_load("header", SKIP_EN ? 4 : 260, 8'h21, 24'h3FFFFF, 24'h001FFF);
    check("header_last_parse_addr", 64'(parse_addr), 64'h206);
    has_header = 1'b0;

    // Short file with random ack stalls.
    ack_mode = 2;
    parsed_rom_type = 8'h22;
    parsed_rom_size = 8'd1;
    parsed_sram_size = 8'd2;
    start_load(32'd5);
    send_word(32'hDDCCBBAA, 32'd0, 32'd6);
    send_word(32'h11223344, 32'd4, 32'd6);
    finish_load("rand_ack", 3, 8'h22, 24'h0007FF, 24'h000FFF);

    // Reset while the high-half write is stalled.
    ack_mode = 1;
    ack_budget = 1;
    parsed_rom_size = 8'h0C;
    parsed_sram_size = 8'd3;
    start_load(32'd8);
    send_word(32'h44332211, 32'd0, 32'd8);
    repeat (3) @(negedge clk_mem);
    check("stall_req", {63'd0, mem_req}, 64'd1);
    check("stall_write", {24'd0, mem_addr, mem_data}, {24'd0, 24'd2, 16'h4433});
    check("stall_downloading", {63'd0, downloading}, 64'd1);
    pulses_before = cfg_pulses;
    #2 reset = 1'b1;
    #1 check_all_zero("abort");
    @(negedge clk_mem);
    exp_wr.delete();
    exp_parse.delete();
    reset = 1'b0;
    ack_mode = 0;
    repeat (6) @(negedge clk_mem);
    check("no_cfg_after_abort", 64'(cfg_pulses), 64'(pulses_before));
    check("idle_after_abort", {62'd0, in_ready, downloading}, 64'd0);
    load_vec(vecs[0], "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
